// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared types and constants for the UART command controller.
package uart_cmd_pkg;

  // Frame position: which byte of the 5-byte command is expected next.
  typedef enum logic [2:0] {
    S_SYNC = 3'd0,
    S_ADDR = 3'd1,
    S_DHI  = 3'd2,
    S_DLO  = 3'd3,
    S_CSUM = 3'd4
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         FRAME_LEN = 5;
  localparam int         REG_W     = 16;

  // Expected checksum byte of a frame: XOR of the three payload bytes.
  function automatic logic [7:0] frame_csum(input logic [7:0] addr,
                                            input logic [7:0] dhi,
                                            input logic [7:0] dlo);
    return addr ^ dhi ^ dlo;
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_sat_cnt8.sv
// 8-bit event counter that sticks at 255 instead of wrapping.
module sat_cnt8 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       inc_i,
  output logic [7:0] cnt_o
);

  logic [7:0] cnt_q;

  // Count increment requests, holding at full scale.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else if (inc_i && (cnt_q != 8'hFF)) begin
      cnt_q <= cnt_q + 8'd1;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: frames received bytes into 5-byte write
// commands (A5, ADDR, DHI, DLO, CSUM), validates them and commits good
// ones into a 16-bit configuration register file. An inter-byte timeout
// drops stalled frames; error counters record rejected frames.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int TIMEOUT_CLKS = CLKS_PER_BIT * 10 * 4,
  parameter int NUM_REGS     = 8
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  input  logic                      i_Rx_DV,
  input  logic [7:0]                i_Rx_Byte,
  output logic [REG_W*NUM_REGS-1:0] o_Regs,
  output logic                      o_Wr_Strobe,
  output logic [7:0]                o_Wr_Addr,
  output logic                      o_Busy,
  output logic [7:0]                o_Err_Csum,
  output logic [7:0]                o_Err_Addr,
  output logic [7:0]                o_Err_Tmo
);

  localparam int TMR_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CLKS - 1);

  state_e state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  logic [7:0] addr_q;
  logic [7:0] dhi_q;
  logic [7:0] dlo_q;

  logic [NUM_REGS-1:0][REG_W-1:0] regs_q;
  logic                           wr_strobe_q;
  logic [7:0]                     wr_addr_q;
  logic                           busy_q;

  logic cap_addr_s;
  logic cap_dhi_s;
  logic cap_dlo_s;
  logic commit_s;
  logic csum_err_s;
  logic addr_err_s;
  logic tmo_s;
  logic addr_ok_s;

  // Widen before comparing so NUM_REGS = 256 accepts every address.
  assign addr_ok_s = ({1'b0, addr_q} < 9'(NUM_REGS));

  // Frame state and inter-byte timer registers.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= S_SYNC;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Next-state decode; a byte arriving on the expiry cycle takes priority
  // over the timeout.
  always_comb begin
    state_d    = state_q;
    timer_d    = '0;
    cap_addr_s = 1'b0;
    cap_dhi_s  = 1'b0;
    cap_dlo_s  = 1'b0;
    commit_s   = 1'b0;
    csum_err_s = 1'b0;
    addr_err_s = 1'b0;
    tmo_s      = 1'b0;
    if (i_Rx_DV) begin
      case (state_q)
        S_SYNC: begin
          if (i_Rx_Byte == SYNC_BYTE) begin
            state_d = S_ADDR;
          end else begin
            state_d = S_SYNC;
          end
        end
        S_ADDR: begin
          cap_addr_s = 1'b1;
          state_d    = S_DHI;
        end
        S_DHI: begin
          cap_dhi_s = 1'b1;
          state_d   = S_DLO;
        end
        S_DLO: begin
          cap_dlo_s = 1'b1;
          state_d   = S_CSUM;
        end
        S_CSUM: begin
          state_d = S_SYNC;
          // Checksum outranks the range check: a doubly bad frame counts once.
          if (i_Rx_Byte != frame_csum(addr_q, dhi_q, dlo_q)) begin
            csum_err_s = 1'b1;
          end else if (!addr_ok_s) begin
            addr_err_s = 1'b1;
          end else begin
            commit_s = 1'b1;
          end
        end
        default: begin
          state_d = S_SYNC;
        end
      endcase
    end else if (state_q != S_SYNC) begin
      if (timer_q == TMR_LAST) begin
        state_d = S_SYNC;
        tmo_s   = 1'b1;
      end else begin
        timer_d = timer_q + TMR_W'(1);
      end
    end else begin
      timer_d = '0;
    end
  end

  // Payload capture, register-file commit and registered status outputs.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      addr_q      <= 8'd0;
      dhi_q       <= 8'd0;
      dlo_q       <= 8'd0;
      regs_q      <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 8'd0;
      busy_q      <= 1'b0;
    end else begin
      wr_strobe_q <= commit_s;
      busy_q      <= (state_d != S_SYNC);
      if (cap_addr_s) begin
        addr_q <= i_Rx_Byte;
      end
      if (cap_dhi_s) begin
        dhi_q <= i_Rx_Byte;
      end
      if (cap_dlo_s) begin
        dlo_q <= i_Rx_Byte;
      end
      if (commit_s) begin
        wr_addr_q <= addr_q;
        for (int k = 0; k < NUM_REGS; k++) begin
          if (addr_q == 8'(k)) begin
            regs_q[k] <= {dhi_q, dlo_q};
          end
        end
      end
    end
  end

  sat_cnt8 u_cnt_csum (
    .clk_i (i_Clock),
    .rst_i (i_Reset),
    .inc_i (csum_err_s),
    .cnt_o (o_Err_Csum)
  );

  sat_cnt8 u_cnt_addr (
    .clk_i (i_Clock),
    .rst_i (i_Reset),
    .inc_i (addr_err_s),
    .cnt_o (o_Err_Addr)
  );

  sat_cnt8 u_cnt_tmo (
    .clk_i (i_Clock),
    .rst_i (i_Reset),
    .inc_i (tmo_s),
    .cnt_o (o_Err_Tmo)
  );

  assign o_Regs      = regs_q;
  assign o_Wr_Strobe = wr_strobe_q;
  assign o_Wr_Addr   = wr_addr_q;
  assign o_Busy      = busy_q;

endmodule
